// File: rtl/alu_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq_if : funct handshake plus decode/multiplier control bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_ctrl_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] funct;
  logic       out_valid;
  logic [2:0] alu_op;
  logic       sht_op;
  logic [1:0] res_sel;
  logic       illegal;
  logic       mul_start;
  logic       mul_busy;
  logic       hilo_we;

  modport master (
    output in_valid, funct,
    input  in_ready, out_valid, alu_op, sht_op, res_sel, illegal,
           mul_start, mul_busy, hilo_we
  );

  modport slave (
    input  in_valid, funct,
    output in_ready, out_valid, alu_op, sht_op, res_sel, illegal,
           mul_start, mul_busy, hilo_we
  );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq : registered ALU control decode with MULTU sequencer/interlock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [2:0]       alu_op_q;
  logic             sht_op_q;
  logic [1:0]       res_sel_q;
  logic             illegal_q;
  logic             mul_start_q;
  logic             mul_busy_q;
  logic             hilo_we_q;

  logic [2:0] alu_op_d;
  logic       sht_op_d;
  logic [1:0] res_sel_d;
  logic       illegal_d;
  logic       hilo_dep;
  logic       accept;

  // Anything touching the multiplier or HI/LO must wait until hilo_we has landed
  assign hilo_dep     = (bus.funct == FN_MULTU) || (bus.funct == FN_MFHI) ||
                        (bus.funct == FN_MFLO);
  assign bus.in_ready = !(mul_busy_q && hilo_dep);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_op_d  = 3'b000;
    sht_op_d  = 1'b0;
    res_sel_d = 2'b00;
    illegal_d = 1'b0;
    case (bus.funct)
      FN_AND:   alu_op_d  = 3'b000;
      FN_OR:    alu_op_d  = 3'b001;
      FN_ADD:   alu_op_d  = 3'b010;
      FN_SUB:   alu_op_d  = 3'b110;
      FN_SLT:   alu_op_d  = 3'b111;
      FN_SLL:   res_sel_d = 2'b01;
      FN_SRL: begin
        res_sel_d = 2'b01;
        sht_op_d  = 1'b1;
      end
      FN_MFHI:  res_sel_d = 2'b10;
      FN_MFLO:  res_sel_d = 2'b11;
      FN_MULTU: res_sel_d = 2'b00;
      default: begin
        illegal_d = 1'b1;
        alu_op_d  = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= 3'b000;
      sht_op_q    <= 1'b0;
      res_sel_q   <= 2'b00;
      illegal_q   <= 1'b0;
      mul_start_q <= 1'b0;
      mul_busy_q  <= 1'b0;
      hilo_we_q   <= 1'b0;
    end else begin
      out_valid_q <= accept;
      mul_start_q <= 1'b0;
      hilo_we_q   <= 1'b0;
      if (accept) begin
        alu_op_q  <= alu_op_d;
        sht_op_q  <= sht_op_d;
        res_sel_q <= res_sel_d;
        illegal_q <= illegal_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept && (bus.funct == FN_MULTU)) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            mul_start_q <= 1'b1;
            mul_busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // Counter parks at its last value instead of wrapping
          if (cnt_q == CNT_LAST) begin
            state_q   <= ST_DONE;
            hilo_we_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          mul_busy_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.sht_op    = sht_op_q;
  assign bus.res_sel   = res_sel_q;
  assign bus.illegal   = illegal_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_busy  = mul_busy_q;
  assign bus.hilo_we   = hilo_we_q;

endmodule

`default_nettype wire
